fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 129 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / HI-LO stall detection and mult/div busy tracker.
// Optional stall-cycle statistics counter enabled by defining FWD_STALL_STATS_EN.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int MD_LAT  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           ex_rs,
    input  logic [4:0]           ex_rt,
    input  logic [NUM_SRC-1:0]   src_wr,
    input  logic [5*NUM_SRC-1:0] src_addr,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic                 idex_memread,
    input  logic [4:0]           idex_wraddr,
    input  logic                 md_start,
    input  logic                 id_uses_hilo,
    output logic [2:0]           fwd_a,
    output logic [2:0]           fwd_b,
    output logic                 stall,
    output logic                 md_busy,
    output logic                 md_done
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [15:0]          stall_cycles
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         md_done_q, md_done_d;

    logic [NUM_SRC-1:0] match_a;
    logic [NUM_SRC-1:0] match_b;
    logic               load_use_stall;
    logic               hilo_stall;

    // Register 0 is hardwired, so a source claiming to write it never matches.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
            assign match_a[gi] = src_wr[gi] && (src_addr[5*gi +: 5] == ex_rs) && (ex_rs != 5'd0);
            assign match_b[gi] = src_wr[gi] && (src_addr[5*gi +: 5] == ex_rt) && (ex_rt != 5'd0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching source wins.
    always_comb begin
        fwd_a = 3'd0;
        fwd_b = 3'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (match_a[k]) fwd_a = 3'(k + 1);
            if (match_b[k]) fwd_b = 3'(k + 1);
        end
    end

    assign load_use_stall = idex_memread && (idex_wraddr != 5'd0) &&
                            ((id_rs_used && (idex_wraddr == id_rs)) ||
                             (id_rt_used && (idex_wraddr == id_rt)));
    assign hilo_stall     = id_uses_hilo && (state_q == BUSY);
    assign stall          = load_use_stall || hilo_stall;

    assign md_busy = (state_q == BUSY);
    assign md_done = md_done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = 5'(MD_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d   = IDLE;
                    md_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: vector table for the combinational paths,
// hand-written sequences for the mult/div tracker, reset abort and optional stall counter.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  ex_rs, ex_rt;
    logic [1:0]  src_wr;
    logic [9:0]  src_addr;
    logic [4:0]  id_rs, id_rt;
    logic        id_rs_used, id_rt_used;
    logic        idex_memread;
    logic [4:0]  idex_wraddr;
    logic        md_start, id_uses_hilo;
    logic [2:0]  fwd_a, fwd_b;
    logic        stall, md_busy, md_done;
`ifdef FWD_STALL_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit #(.NUM_SRC(2), .MD_LAT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .src_wr       (src_wr),
        .src_addr     (src_addr),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .idex_memread (idex_memread),
        .idex_wraddr  (idex_wraddr),
        .md_start     (md_start),
        .id_uses_hilo (id_uses_hilo),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .md_busy      (md_busy),
        .md_done      (md_done)
`ifdef FWD_STALL_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [1:0] wr;
        logic [9:0] addr;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       rs_used;
        logic       rt_used;
        logic       memread;
        logic [4:0] wraddr;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_rs = 5'd0; ex_rt = 5'd0; src_wr = 2'b00; src_addr = 10'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        idex_memread = 1'b0; idex_wraddr = 5'd0;
        md_start = 1'b0; id_uses_hilo = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; src_wr = v.wr; src_addr = v.addr;
        id_rs = v.id_rs; id_rt = v.id_rt; id_rs_used = v.rs_used; id_rt_used = v.rt_used;
        idex_memread = v.memread; idex_wraddr = v.wraddr;
    endtask

    // One mult/div run starting in cycle 0; optional re-starts while busy and at the final busy cycle.
    task automatic md_run(input string tag, input bit restart);
        md_start = 1'b1;
        id_uses_hilo = 1'b1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            md_start = restart && (c == 4 || c == 8);
            chk($sformatf("%s_c%0d_busy", tag, c), 32'(md_busy), 32'((c >= 1 && c <= 8) ? 1 : 0));
            chk($sformatf("%s_c%0d_done", tag, c), 32'(md_done), 32'((c == 9) ? 1 : 0));
            chk($sformatf("%s_c%0d_stall", tag, c), 32'(stall), 32'((c >= 1 && c <= 8) ? 1 : 0));
            $display("%s cycle=%0d busy=%0b done=%0b stall=%0b", tag, c, md_busy, md_done, stall);
        end
        md_start = 1'b0;
        id_uses_hilo = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'd8,  5'd0, 2'b11, {5'd8, 5'd8},  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd1, 3'd0, 1'b0};
        vecs[1] = '{5'd8,  5'd0, 2'b10, {5'd8, 5'd8},  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd2, 3'd0, 1'b0};
        vecs[2] = '{5'd0,  5'd0, 2'b01, {5'd3, 5'd0},  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 3'd0, 1'b0};
        vecs[3] = '{5'd6,  5'd5, 2'b11, {5'd6, 5'd5},  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd2, 3'd1, 1'b0};
        vecs[4] = '{5'd6,  5'd5, 2'b00, {5'd6, 5'd5},  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 3'd0, 1'b0};
        vecs[5] = '{5'd0,  5'd0, 2'b00, 10'd0,         5'd0,  5'd9, 1'b0, 1'b1, 1'b1, 5'd9,  3'd0, 3'd0, 1'b1};
        vecs[6] = '{5'd0,  5'd0, 2'b00, 10'd0,         5'd0,  5'd9, 1'b0, 1'b0, 1'b1, 5'd9,  3'd0, 3'd0, 1'b0};
        vecs[7] = '{5'd0,  5'd0, 2'b00, 10'd0,         5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 5'd0,  3'd0, 3'd0, 1'b0};
        vecs[8] = '{5'd0,  5'd0, 2'b00, 10'd0,         5'd9,  5'd0, 1'b1, 1'b0, 1'b0, 5'd9,  3'd0, 3'd0, 1'b0};
        vecs[9] = '{5'd7,  5'd7, 2'b11, {5'd7, 5'd1},  5'd12, 5'd3, 1'b1, 1'b0, 1'b1, 5'd12, 3'd2, 3'd2, 1'b1};

        clear_inputs();
        reset = 1'b1;
        #2;
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_done", 32'(md_done), 32'd0);
        apply_vec(vecs[0]);
        #1;
        chk("reset_fwd_a_comb", 32'(fwd_a), 32'd1);
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            $display("vec%0d fwd_a=%0d fwd_b=%0d stall=%0b", i, fwd_a, fwd_b, stall);
        end
        clear_inputs();
        tick();

        md_run("md_plain", 1'b0);
        tick();
        md_run("md_restart", 1'b1);
        chk("md_restart_idle_after", 32'(md_busy), 32'd0);
        tick();
        chk("md_restart_not_accepted", 32'(md_busy), 32'd0);

        // Reset arriving mid-run: busy drops at once and no completion pulse follows.
        md_start = 1'b1;
        id_uses_hilo = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            md_start = 1'b0;
        end
        chk("abort_busy_before", 32'(md_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy_now", 32'(md_busy), 32'd0);
        chk("abort_stall_now", 32'(stall), 32'd0);
        $display("abort busy=%0b stall=%0b", md_busy, stall);
        #2;
        reset = 1'b0;
        for (int c = 6; c <= 12; c++) begin
            tick();
            chk($sformatf("abort_c%0d_done", c), 32'(md_done), 32'd0);
            chk($sformatf("abort_c%0d_busy", c), 32'(md_busy), 32'd0);
        end
        clear_inputs();

`ifdef FWD_STALL_STATS_EN
        #2;
        reset = 1'b1;
        #1;
        chk("stats_reset", 32'(stall_cycles), 32'd0);
        reset = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) begin
            idex_memread = 1'b1; idex_wraddr = 5'd9; id_rt = 5'd9; id_rt_used = 1'b1;
            tick();
            clear_inputs();
            tick();
        end
        chk("stats_load_use", 32'(stall_cycles), 32'd3);
        md_start = 1'b1;
        id_uses_hilo = 1'b1;
        tick();
        md_start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        id_uses_hilo = 1'b0;
        chk("stats_eleven", 32'(stall_cycles), 32'd11);
        $display("stats stall_cycles=%0d", stall_cycles);
        idex_memread = 1'b1; idex_wraddr = 5'd9; id_rs = 5'd9; id_rs_used = 1'b1;
        for (int n = 0; n < 70000; n++) tick();
        clear_inputs();
        chk("stats_saturate", 32'(stall_cycles), 32'h0000FFFF);
        $display("stats stall_cycles=%0h", stall_cycles);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
